// File: rtl/ai_wb_stream_loader.sv
// ai_wb_stream_loader: on request, streams one layer's weights followed by its
// biases from a 1-cycle-latency parameter memory to a valid/ready consumer.
// A 2-entry fall-through FIFO absorbs consumer stalls. Returning memory data
// bypasses the FIFO when it is empty, so the stream runs at one word per cycle.
module ai_wb_stream_loader #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned LAYERS    = 4,
    parameter int unsigned LAYER_LEN = 64,
    parameter int unsigned NBIAS     = 8,
    parameter int unsigned ADDR_W    = $clog2(LAYERS * (LAYER_LEN + NBIAS)),
    parameter int unsigned IDX_W     = $clog2(LAYER_LEN + NBIAS),
    parameter int unsigned LID_W     = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [LID_W-1:0]  layer_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [IDX_W-1:0]  out_index_o,
    output logic              out_is_bias_o,
    output logic              out_last_o
);

    localparam int unsigned TOTAL = LAYER_LEN + NBIAS;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              is_bias;
        logic              last;
    } entry_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic              r_mem_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_err;
    logic              r_inflight;
    logic [IDX_W-1:0]  r_inf_idx;
    logic              r_inf_bias;
    logic              r_inf_last;
    entry_t            r_fifo [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_base_nxt;
    logic [CNT_W-1:0]  w_rd_cnt_nxt;
    logic              w_en_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_err_nxt;
    logic              w_fifo_nempty;
    logic              w_xfer;
    logic              w_pop;
    logic              w_push;
    logic [1:0]        w_count_nxt;
    entry_t            w_out;

    // Output word: FIFO head if present, else the word returning from memory
    always_comb begin
        w_out = '0;
        if (w_fifo_nempty) begin
            w_out = r_fifo[r_rd_ptr];
        end else if (r_inflight) begin
            w_out = '{data: mem_data_i, idx: r_inf_idx, is_bias: r_inf_bias, last: r_inf_last};
        end
    end

    assign w_fifo_nempty = (r_count != 2'd0);
    assign out_valid_o   = w_fifo_nempty | r_inflight;
    assign w_xfer        = out_valid_o & out_ready_i;
    assign w_pop         = w_xfer & w_fifo_nempty;
    assign w_push        = r_inflight & ~(w_xfer & ~w_fifo_nempty);
    assign w_count_nxt   = r_count + 2'(w_push) - 2'(w_pop);

    assign out_data_o    = w_out.data;
    assign out_index_o   = w_out.idx;
    assign out_is_bias_o = w_out.is_bias;
    assign out_last_o    = w_out.last;
    assign busy_o        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done_o        = (r_state == S_DONE);
    assign err_o         = r_err;
    assign mem_en_o      = r_mem_en;
    assign mem_addr_o    = r_mem_addr;

    // Next state, and the read to issue next cycle (FIFO words plus in-flight read stay below 2)
    always_comb begin
        w_state_nxt  = r_state;
        w_base_nxt   = r_base;
        w_rd_cnt_nxt = r_rd_cnt + CNT_W'(r_mem_en);
        w_en_nxt     = 1'b0;
        w_addr_nxt   = r_mem_addr;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (32'(layer_i) < LAYERS) begin
                        w_state_nxt  = S_RUN;
                        w_base_nxt   = ADDR_W'(32'(layer_i) * TOTAL);
                        w_rd_cnt_nxt = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_rd_cnt_nxt == CNT_W'(TOTAL)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_xfer && w_out.last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if ((w_state_nxt == S_RUN) && ((32'(w_count_nxt) + 32'(r_mem_en)) < 32'd2)
            && (w_rd_cnt_nxt < CNT_W'(TOTAL))) begin
            w_en_nxt   = 1'b1;
            w_addr_nxt = w_base_nxt + ADDR_W'(w_rd_cnt_nxt);
        end
    end

    // State, read issue, in-flight tracking and FIFO storage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_rd_cnt   <= '0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_err      <= 1'b0;
            r_inflight <= 1'b0;
            r_inf_idx  <= '0;
            r_inf_bias <= 1'b0;
            r_inf_last <= 1'b0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_base     <= w_base_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_mem_en   <= w_en_nxt;
            r_mem_addr <= w_addr_nxt;
            r_err      <= w_err_nxt;
            r_inflight <= r_mem_en;
            if (r_mem_en) begin
                r_inf_idx  <= IDX_W'(r_rd_cnt);
                r_inf_bias <= (r_rd_cnt >= CNT_W'(LAYER_LEN));
                r_inf_last <= (r_rd_cnt == CNT_W'(TOTAL - 1));
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= '{data: mem_data_i, idx: r_inf_idx,
                                      is_bias: r_inf_bias, last: r_inf_last};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_ai_wb_stream_loader.sv
// Directed bench for ai_wb_stream_loader: table of stream scenarios plus
// hand-written sequences for invalid layer and mid-stream reset.
module tb_ai_wb_stream_loader;

    localparam int DW  = 4;
    localparam int NL  = 4;
    localparam int LL  = 64;
    localparam int NB  = 8;
    localparam int TOT = LL + NB;
    localparam int AW  = 9;
    localparam int IW  = 7;
    localparam int LW  = 3;

    logic          clk;
    logic          reset;
    logic          start_i;
    logic [LW-1:0] layer_i;
    logic          busy_o, done_o, err_o;
    logic          mem_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [IW-1:0] out_index_o;
    logic          out_is_bias_o;
    logic          out_last_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         layer;
        logic [3:0] pat;      // ready pattern, bit (k % 4) drives cycle k
        int         stall;    // ready held low for this many cycles first
        bit         second;   // issue a second start mid-stream
        int         alt;      // layer used by the second start
        int         base;     // expected first address
        int         done_k;   // expected done cycle index, -1 = unchecked
    } vec_t;

    vec_t tbl [4];

    ai_wb_stream_loader #(
        .DATA_W(DW), .LAYERS(NL), .LAYER_LEN(LL), .NBIAS(NB),
        .ADDR_W(AW), .IDX_W(IW), .LID_W(LW)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .layer_i(layer_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_index_o(out_index_o),
        .out_is_bias_o(out_is_bias_o), .out_last_o(out_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memf(input int a);
        return DW'(a * 5 + a / 9 + 3);
    endfunction

    // Parameter memory model, one cycle read latency
    always @(posedge clk) begin
        if (mem_en_o) mem_data_i <= memf(int'(mem_addr_o));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"},  busy_o, 0);
        chk({nm, "_done"},  done_o, 0);
        chk({nm, "_err"},   err_o, 0);
        chk({nm, "_en"},    mem_en_o, 0);
        chk({nm, "_addr"},  mem_addr_o, 0);
        chk({nm, "_valid"}, out_valid_o, 0);
        chk({nm, "_data"},  out_data_o, 0);
        chk({nm, "_index"}, out_index_o, 0);
        chk({nm, "_bias"},  out_is_bias_o, 0);
        chk({nm, "_last"},  out_last_o, 0);
    endtask

    // Start a stream from IDLE and check every read and transfer until done
    task automatic run_stream(input vec_t v);
        int exp_idx = 0;
        int reads = 0;
        int gaps = 0;
        bit fin = 0;
        bit pv = 0, pr = 0;
        logic [DW-1:0] hd = '0;
        logic [IW-1:0] hi = '0;
        logic hb = 0, hl = 0;
        layer_i = LW'(v.layer);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("lat_en", mem_en_o, 1);
        chk("lat_busy", busy_o, 1);
        for (int k = 0; k < 3000 && !fin; k++) begin
            out_ready_i = (k < v.stall) ? 1'b0 : v.pat[k % 4];
            start_i = v.second && (k == 3);
            if (v.second && k == 3) layer_i = LW'(v.alt);
            if (mem_en_o) begin
                chk("rd_overrun", reads < TOT, 1);
                chk("rd_addr", mem_addr_o, v.base + reads);
                reads++;
            end
            if (v.stall > 0 && k == v.stall - 1) chk("stall_reads", reads <= 2, 1);
            if (k == 1) begin
                chk("first_valid", out_valid_o, 1);
                chk("first_index", out_index_o, 0);
            end
            if (out_valid_o) begin
                if (pv && !pr) begin
                    chk("hold_data", out_data_o, hd);
                    chk("hold_index", out_index_o, hi);
                    chk("hold_bias", out_is_bias_o, hb);
                    chk("hold_last", out_last_o, hl);
                end
                if (out_ready_i) begin
                    chk("xfer_index", out_index_o, exp_idx);
                    chk("xfer_data", out_data_o, memf(v.base + exp_idx));
                    chk("xfer_bias", out_is_bias_o, exp_idx >= LL);
                    chk("xfer_last", out_last_o, exp_idx == TOT - 1);
                    exp_idx++;
                end
            end else if (v.pat == 4'hF && exp_idx > 0 && exp_idx < TOT) begin
                gaps++;
            end
            if (done_o) begin
                chk("done_count", exp_idx, TOT);
                if (v.done_k >= 0) chk("done_cycle", k, v.done_k);
                fin = 1;
            end
            pv = out_valid_o;
            pr = out_ready_i;
            hd = out_data_o;
            hi = out_index_o;
            hb = out_is_bias_o;
            hl = out_last_o;
            tick();
        end
        start_i = 1'b0;
        out_ready_i = 1'b0;
        chk("done_seen", fin, 1);
        chk("gaps", gaps, 0);
        chk("done_pulse", done_o, 0);
        chk("post_busy", busy_o, 0);
        chk("post_en", mem_en_o, 0);
    endtask

    initial begin
        int n;
        int guard;
        reset       = 1'b1;
        start_i     = 1'b0;
        layer_i     = '0;
        out_ready_i = 1'b0;

        tbl[0] = '{layer: 0, pat: 4'hF, stall: 0,  second: 0, alt: 0, base: 0,   done_k: 73};
        tbl[1] = '{layer: 3, pat: 4'h9, stall: 0,  second: 0, alt: 0, base: 216, done_k: -1};
        tbl[2] = '{layer: 2, pat: 4'hF, stall: 0,  second: 1, alt: 1, base: 144, done_k: 73};
        tbl[3] = '{layer: 1, pat: 4'hF, stall: 20, second: 0, alt: 0, base: 72,  done_k: 92};

        repeat (3) tick();
        chk_zero("rst_held");
        reset = 1'b0;
        tick();
        chk_zero("rst_rel");

        for (int i = 0; i < 4; i++) begin
            run_stream(tbl[i]);
            tick();
        end

        // Invalid layer: error pulse only, no activity
        layer_i = LW'(4);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("inv_err", err_o, 1);
        chk("inv_busy", busy_o, 0);
        chk("inv_en", mem_en_o, 0);
        tick();
        chk("inv_err_pulse", err_o, 0);
        for (int i = 0; i < 4; i++) begin
            chk("inv_quiet", {busy_o, mem_en_o, done_o}, 0);
            tick();
        end

        // Reset after 30 transfers while a read is in flight
        layer_i = '0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        out_ready_i = 1'b1;
        n = 0;
        guard = 0;
        while (n < 30 && guard < 200) begin
            if (out_valid_o) n++;
            if (n < 30) tick();
            guard++;
        end
        chk("mid_count", n, 30);
        chk("mid_inflight", mem_en_o, 1);
        reset = 1'b1;
        tick();
        chk_zero("mid_rst");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_quiet", {out_valid_o, done_o, busy_o}, 0);
        end
        out_ready_i = 1'b0;
        run_stream('{layer: 1, pat: 4'hF, stall: 0, second: 0, alt: 0, base: 72, done_k: 73});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
